// File: rtl/adc_playback_gen_if.sv
// Control, record-load and playback output signals of adc_playback_gen.
// master drives configuration and load; slave is the playback source.
interface adc_playback_gen_if #(
  parameter int NCH = 3,
  parameter int R   = 2,
  parameter int AW  = 15
);
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [NCH*R-1:0]  load_data;
  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [AW:0]       n_record;
  logic [AW-1:0]     offset;
  logic [15:0]       rate_div;
  logic [NCH*R-1:0]  adc_data;
  logic              adc_valid;
  logic              busy;
  logic              done;
  logic              wrap_pulse;
  logic              cfg_err;
  logic [31:0]       chip_cnt;
  logic [31:0]       epoch_cnt;
  logic              epoch_pulse;

  modport master (
    output load_we, load_addr, load_data,
    output start, stop, loop_mode,
    output n_record, offset, rate_div,
    input  adc_data, adc_valid, busy, done,
    input  wrap_pulse, cfg_err,
    input  chip_cnt, epoch_cnt, epoch_pulse
  );

  modport slave (
    input  load_we, load_addr, load_data,
    input  start, stop, loop_mode,
    input  n_record, offset, rate_div,
    output adc_data, adc_valid, busy, done,
    output wrap_pulse, cfg_err,
    output chip_cnt, epoch_cnt, epoch_pulse
  );
endinterface

// File: rtl/adc_playback_gen.sv
// Replays a preloaded multi-channel ADC record with offset, length,
// rate divider and loop/one-shot mode, plus a start-aligned epoch time base.
module adc_playback_gen #(
  parameter int NCH       = 3,
  parameter int R         = 2,
  parameter int DEPTH     = 32768,
  parameter int EPOCH_LEN = 100000
) (
  input  logic clk,
  input  logic resetn,
  adc_playback_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = NCH * R;
  localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [31:0]  ELAST   = 32'(EPOCH_LEN - 1);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_nx;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   n_rec;
  logic [AW:0]   scnt;
  logic [AW-1:0] ptr;
  logic [15:0]   rdiv;
  logic [15:0]   div;
  logic          loop_r;
  logic [W-1:0]  data;
  logic          valid, wrap, done, err;
  logic [31:0]   chip, epoch;

  logic cfg_ok, idle_req, accept, reject;
  logic tick, emit, last, ptr_end, chip_end;

  assign cfg_ok   = (bus.n_record != '0) && (bus.n_record <= DEPTH_W)
                 && ({1'b0, bus.offset} < bus.n_record);
  assign idle_req = (state == IDLE) && bus.start && !bus.stop;
  assign accept   = idle_req && cfg_ok;
  assign reject   = idle_req && !cfg_ok;
  assign tick     = (state == PLAY) && (div == '0);
  assign emit     = tick && !bus.stop;
  assign last     = tick && !loop_r && (scnt == n_rec - 1'b1);
  assign ptr_end  = ({1'b0, ptr} == n_rec - 1'b1);
  assign chip_end = (chip == ELAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = PLAY;
      PLAY: if (bus.stop || last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_rec  <= '0;
      scnt   <= '0;
      ptr    <= '0;
      rdiv   <= '0;
      div    <= '0;
      loop_r <= 1'b0;
    end else if (accept) begin
      n_rec  <= bus.n_record;
      scnt   <= '0;
      ptr    <= bus.offset;
      rdiv   <= bus.rate_div;
      div    <= '0;
      loop_r <= bus.loop_mode;
    end else if (state == PLAY) begin
      div <= (div == rdiv) ? '0 : div + 16'd1;
      if (tick) begin
        ptr  <= ptr_end ? '0 : ptr + AW'(1);
        scnt <= scnt + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      data  <= '0;
    end else begin
      valid <= emit;
      wrap  <= emit && ptr_end;
      done  <= emit && last;
      if (accept)      err <= 1'b0;
      else if (reject) err <= 1'b1;
      if (emit) data <= mem[ptr];
    end
  end

  // Write port has no reset; read-first because the read above sees old data.
  always_ff @(posedge clk) begin
    if (bus.load_we) mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chip  <= '0;
      epoch <= '0;
    end else if (accept) begin
      chip  <= '0;
      epoch <= '0;
    end else if (state == PLAY) begin
      if (chip_end) epoch <= epoch + 32'd1;
      chip <= (chip_end || state_nx == IDLE) ? '0 : chip + 32'd1;
    end
  end

  assign bus.adc_data    = data;
  assign bus.adc_valid   = valid;
  assign bus.busy        = (state == PLAY);
  assign bus.done        = done;
  assign bus.wrap_pulse  = wrap;
  assign bus.cfg_err     = err;
  assign bus.chip_cnt    = chip;
  assign bus.epoch_cnt   = epoch;
  assign bus.epoch_pulse = (state == PLAY) && chip_end;
endmodule
